// File: rtl/ysyx_040978_div_unit_if.sv
// Request/response bundle between the EXU and the integer divider.
//
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both high; a result transfers on a rising clock edge where
// out_valid and out_ready are both high. Once out_valid is raised, it stays
// high and quotient/remainder stay stable until that transfer or a flush.
// The requester may change dividend/divisor/div_signed/divw freely after
// the accepting edge.
interface ysyx_040978_div_unit_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            div_signed;
    logic            divw;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    // Divider FSM state, for checkers and debug: 0 IDLE, 1 CALC, 2 DONE
    logic [1:0]      state_dbg;

    modport master (
        output flush, in_valid, div_signed, divw, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, state_dbg
    );

    modport slave (
        input  flush, in_valid, div_signed, divw, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, state_dbg
    );
endinterface

// File: rtl/ysyx_040978_div_unit.sv
// Multi-cycle radix-2 restoring integer divider for the EXU.
// Handles signed/unsigned XLEN divides and RV64 word-mode divides
// (results sign-extended from bit WLEN-1), RISC-V divide-by-zero and
// signed-overflow results, output back-pressure and pipeline flush.
// Optional build macro DIV_ZERO_BYPASS_EN: divide-by-zero and signed
// overflow skip the iterative phase and complete one cycle after accept.
module ysyx_040978_div_unit #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input logic                   clock,
    input logic                   reset,
    ysyx_040978_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] N_X = CW'(XLEN);
    localparam logic [CW-1:0] N_W = CW'(WLEN);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WLEN-1:0] MIN_W = {1'b1, {(WLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   quotient_q;
    logic [XLEN-1:0]   remainder_q;
    logic [CW-1:0]     counter;

    // Partial remainder (upper half) and dividend/quotient bits (lower half)
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   abs_dvs_q;
    logic              word_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              div_zero_q;
    logic              ovf_q;
    logic [XLEN-1:0]   raw_dvd_q;

    // Accept-side operand decode
    logic              in_word;
    logic [WLEN-1:0]   dvd_lo;
    logic [WLEN-1:0]   dvs_lo;
    logic              dvd_sign;
    logic              dvs_sign;
    logic [XLEN-1:0]   dvd_n;
    logic [XLEN-1:0]   dvs_n;
    logic [XLEN-1:0]   dvd_abs_full;
    logic [XLEN-1:0]   dvs_abs_full;
    logic [XLEN-1:0]   abs_dvd;
    logic [XLEN-1:0]   abs_dvs;
    logic [XLEN-1:0]   raw_dvd;
    logic              is_zero;
    logic              is_ovf;

    // One restoring step
    logic [XLEN:0]     top;
    logic              borrow;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] acc_next;

    // Sign correction, word-mode extension and special-case result mux
    function automatic logic [2*XLEN-1:0] fix_result(
        input logic [XLEN-1:0] uq,
        input logic [XLEN-1:0] ur,
        input logic            word,
        input logic            qn,
        input logic            rn,
        input logic            dz,
        input logic            ovf,
        input logic [XLEN-1:0] raw
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        q = qn ? (~uq + 1'b1) : uq;
        r = rn ? (~ur + 1'b1) : ur;
        if (word) begin
            q = {{(XLEN-WLEN){q[WLEN-1]}}, q[WLEN-1:0]};
            r = {{(XLEN-WLEN){r[WLEN-1]}}, r[WLEN-1:0]};
        end
        if (dz) begin
            q = {XLEN{1'b1}};
            r = raw;
        end else if (ovf) begin
            q = raw;
            r = {XLEN{1'b0}};
        end
        return {q, r};
    endfunction

    // Decode operands, magnitudes and special cases of the incoming request
    always_comb begin
        in_word      = bus.divw;
        dvd_lo       = bus.dividend[WLEN-1:0];
        dvs_lo       = bus.divisor[WLEN-1:0];
        dvd_sign     = bus.div_signed & (in_word ? dvd_lo[WLEN-1] : bus.dividend[XLEN-1]);
        dvs_sign     = bus.div_signed & (in_word ? dvs_lo[WLEN-1] : bus.divisor[XLEN-1]);
        dvd_n        = in_word ? {{(XLEN-WLEN){1'b0}}, dvd_lo} : bus.dividend;
        dvs_n        = in_word ? {{(XLEN-WLEN){1'b0}}, dvs_lo} : bus.divisor;
        dvd_abs_full = dvd_sign ? (~dvd_n + 1'b1) : dvd_n;
        dvs_abs_full = dvs_sign ? (~dvs_n + 1'b1) : dvs_n;
        abs_dvd      = in_word ? {{(XLEN-WLEN){1'b0}}, dvd_abs_full[WLEN-1:0]} : dvd_abs_full;
        abs_dvs      = in_word ? {{(XLEN-WLEN){1'b0}}, dvs_abs_full[WLEN-1:0]} : dvs_abs_full;
        raw_dvd      = in_word ? {{(XLEN-WLEN){dvd_lo[WLEN-1]}}, dvd_lo} : bus.dividend;
        is_zero      = in_word ? (dvs_lo == '0) : (bus.divisor == '0);
        is_ovf       = bus.div_signed &
                       (in_word ? ((dvd_lo == MIN_W) && (dvs_lo == '1))
                                : ((bus.dividend == MIN_X) && (bus.divisor == '1)));
    end

    // Shift partial remainder left, trial-subtract divisor, restore on borrow
    always_comb begin
        top    = acc[2*XLEN-1:XLEN-1];
        borrow = top < {1'b0, abs_dvs_q};
        diff   = top[XLEN-1:0] - abs_dvs_q;
        if (borrow) begin
            acc_next = {top[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {diff, acc[XLEN-2:0], 1'b1};
        end
    end

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            counter     <= '0;
            acc         <= '0;
            abs_dvs_q   <= '0;
            word_q      <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            raw_dvd_q   <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            counter     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Word operands are left-aligned so MSB-first iteration stops after WLEN steps
                        acc        <= {{XLEN{1'b0}}, (in_word ? (abs_dvd << (XLEN-WLEN)) : abs_dvd)};
                        abs_dvs_q  <= abs_dvs;
                        word_q     <= in_word;
                        q_neg_q    <= dvd_sign ^ dvs_sign;
                        r_neg_q    <= dvd_sign;
                        div_zero_q <= is_zero;
                        ovf_q      <= is_ovf;
                        raw_dvd_q  <= raw_dvd;
                        in_ready_q <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                        if (is_zero || is_ovf) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            counter     <= '0;
                            {quotient_q, remainder_q} <= fix_result('0, '0, in_word,
                                dvd_sign ^ dvs_sign, dvd_sign, is_zero, is_ovf, raw_dvd);
                        end else begin
                            state   <= CALC;
                            counter <= in_word ? N_W : N_X;
                        end
`else
                        state   <= CALC;
                        counter <= in_word ? N_W : N_X;
`endif
                    end
                end
                CALC: begin
                    acc     <= acc_next;
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        {quotient_q, remainder_q} <= fix_result(acc_next[XLEN-1:0],
                            acc_next[2*XLEN-1:XLEN], word_q, q_neg_q, r_neg_q,
                            div_zero_q, ovf_q, raw_dvd_q);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_ysyx_040978_div_unit.sv
// Directed testbench for ysyx_040978_div_unit (XLEN=64, WLEN=32).
// Cycle numbering: the accepting edge is cycle 0; "cycle k" is the period
// sampled 1 time unit after the k-th edge following it.
module tb_ysyx_040978_div_unit;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

`ifdef DIV_ZERO_BYPASS_EN
    localparam int SPECIAL_LAT_X = 1;
    localparam int SPECIAL_LAT_W = 1;
`else
    localparam int SPECIAL_LAT_X = 65;
    localparam int SPECIAL_LAT_W = 33;
`endif

    ysyx_040978_div_unit_if #(.XLEN(64)) bus();

    ysyx_040978_div_unit #(.XLEN(64), .WLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Driver: present one request for one edge, then scramble the inputs
    task automatic start_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.div_signed = s;
        bus.divw       = w;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.in_valid   = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid   = 1'b0;
        bus.dividend   = {$urandom, $urandom};
        bus.divisor    = {$urandom, $urandom};
        bus.div_signed = 1'($urandom_range(0, 1));
        bus.divw       = 1'($urandom_range(0, 1));
    endtask

    // Driver: wait for out_valid, returning the cycle it was first seen (bounded)
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.quotient !== 64'h0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", bus.quotient); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", bus.remainder); end
        checks++; if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
    endtask

    task automatic test_unsigned();
        int cyc;
        start_op(1'b0, 1'b0, 64'd100, 64'd7);
        wait_valid(cyc);
        checks++; if (cyc !== 65) begin failures++; $display("FAIL udiv_latency got=%0d exp=65", cyc); end
        checks++; if (bus.quotient !== 64'd14) begin failures++; $display("FAIL udiv_q got=%h exp=%h", bus.quotient, 64'd14); end
        checks++; if (bus.remainder !== 64'd2) begin failures++; $display("FAIL udiv_r got=%h exp=%h", bus.remainder, 64'd2); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL udiv_busy got=%b exp=0", bus.in_ready); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL udiv_in_ready_66 got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL udiv_valid_drop got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_signed();
        int cyc;
        start_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_valid(cyc);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL sdiv_m7_2_q got=%h exp=fffffffffffffffd", bus.quotient); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sdiv_m7_2_r got=%h exp=ffffffffffffffff", bus.remainder); end
        step();
        start_op(1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_valid(cyc);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL sdiv_7_m2_q got=%h exp=fffffffffffffffd", bus.quotient); end
        checks++; if (bus.remainder !== 64'd1) begin failures++; $display("FAIL sdiv_7_m2_r got=%h exp=1", bus.remainder); end
        step();
    endtask

    task automatic test_word();
        int cyc;
        start_op(1'b0, 1'b1, 64'h0000_0001_8000_0000, 64'd1);
        wait_valid(cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL divuw_latency got=%0d exp=33", cyc); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divuw_q got=%h exp=ffffffff80000000", bus.quotient); end
        checks++; if (bus.remainder !== 64'd0) begin failures++; $display("FAIL divuw_r got=%h exp=0", bus.remainder); end
        step();
        // Upper operand bits are garbage and must be ignored: -7 / 2 in word mode
        start_op(1'b1, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'h1234_5678_0000_0002);
        wait_valid(cyc);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL divw_q got=%h exp=fffffffffffffffd", bus.quotient); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divw_r got=%h exp=ffffffffffffffff", bus.remainder); end
        step();
    endtask

    task automatic test_div_zero();
        int cyc;
        start_op(1'b1, 1'b0, 64'h1234, 64'd0);
        wait_valid(cyc);
        checks++; if (cyc !== SPECIAL_LAT_X) begin failures++; $display("FAIL divzero_latency got=%0d exp=%0d", cyc, SPECIAL_LAT_X); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divzero_q got=%h exp=ffffffffffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 64'h1234) begin failures++; $display("FAIL divzero_r got=%h exp=1234", bus.remainder); end
        step();
        start_op(1'b0, 1'b1, 64'h5555_0000_8000_0005, 64'hFFFF_0000_0000_0000);
        wait_valid(cyc);
        checks++; if (cyc !== SPECIAL_LAT_W) begin failures++; $display("FAIL divzero_w_latency got=%0d exp=%0d", cyc, SPECIAL_LAT_W); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divzero_w_q got=%h exp=ffffffffffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_8000_0005) begin failures++; $display("FAIL divzero_w_r got=%h exp=ffffffff80000005", bus.remainder); end
        step();
    endtask

    task automatic test_overflow();
        int cyc;
        start_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid(cyc);
        checks++; if (cyc !== SPECIAL_LAT_X) begin failures++; $display("FAIL ovf_latency got=%0d exp=%0d", cyc, SPECIAL_LAT_X); end
        checks++; if (bus.quotient !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_q got=%h exp=8000000000000000", bus.quotient); end
        checks++; if (bus.remainder !== 64'd0) begin failures++; $display("FAIL ovf_r got=%h exp=0", bus.remainder); end
        step();
        start_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        wait_valid(cyc);
        checks++; if (cyc !== SPECIAL_LAT_W) begin failures++; $display("FAIL ovfw_latency got=%0d exp=%0d", cyc, SPECIAL_LAT_W); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL ovfw_q got=%h exp=ffffffff80000000", bus.quotient); end
        checks++; if (bus.remainder !== 64'd0) begin failures++; $display("FAIL ovfw_r got=%h exp=0", bus.remainder); end
        step();
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.out_ready = 1'b0;
        start_op(1'b0, 1'b0, 64'd1000, 64'd3);
        wait_valid(cyc);
        checks++; if (cyc !== 65) begin failures++; $display("FAIL bp_latency got=%0d exp=65", cyc); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cycle=%0d got=%b exp=1", i, bus.out_valid); end
            checks++; if (bus.quotient !== 64'd333) begin failures++; $display("FAIL bp_hold_q cycle=%0d got=%h exp=14d", i, bus.quotient); end
            checks++; if (bus.remainder !== 64'd1) begin failures++; $display("FAIL bp_hold_r cycle=%0d got=%h exp=1", i, bus.remainder); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready cycle=%0d got=%b exp=0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        int   cyc;
        logic seen;
        // A flush in IDLE blocks acceptance of a simultaneous request
        bus.dividend = 64'd50; bus.divisor = 64'd5; bus.div_signed = 1'b0; bus.divw = 1'b0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        checks++; if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL flush_idle_state got=%0d exp=0", bus.state_dbg); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_in_ready got=%b exp=1", bus.in_ready); end
        // Flush at cycle 30 of an in-flight op
        start_op(1'b0, 1'b0, 64'd12345, 64'd10);
        repeat (29) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_stale_valid got=%b exp=0", seen); end
        start_op(1'b0, 1'b0, 64'd12345, 64'd10);
        wait_valid(cyc);
        checks++; if (cyc !== 65) begin failures++; $display("FAIL post_flush_latency got=%0d exp=65", cyc); end
        checks++; if (bus.quotient !== 64'd1234) begin failures++; $display("FAIL post_flush_q got=%h exp=4d2", bus.quotient); end
        checks++; if (bus.remainder !== 64'd5) begin failures++; $display("FAIL post_flush_r got=%h exp=5", bus.remainder); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        logic [127:0] exp;
        int           cyc;
        exp_q.push_back({64'h0FFF_FFFF_FFFF_FFFF, 64'hF});
        exp_q.push_back({64'd14, 64'hFFFF_FFFF_FFFF_FFFE});
        start_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10);
        wait_valid(cyc);
        exp = exp_q.pop_front();
        checks++; if ({bus.quotient, bus.remainder} !== exp) begin failures++; $display("FAIL b2b_first got=%h_%h exp=%h", bus.quotient, bus.remainder, exp); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", bus.in_ready); end
        start_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9);
        wait_valid(cyc);
        exp = exp_q.pop_front();
        checks++; if ({bus.quotient, bus.remainder} !== exp) begin failures++; $display("FAIL b2b_second got=%h_%h exp=%h", bus.quotient, bus.remainder, exp); end
        step();
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_op(1'b0, 1'b0, 64'd999, 64'd4);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.state_dbg !== 2'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", bus.state_dbg); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.quotient !== 64'd0) begin failures++; $display("FAIL rst_mid_q got=%h exp=0", bus.quotient); end
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_stale_valid got=%b exp=0", seen); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.div_signed = 1'b0;
        bus.divw       = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.out_ready  = 1'b1;
        do_reset();
        test_reset();
        test_unsigned();
        test_signed();
        test_word();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
